mips_mdu: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the MIPS pipeline.
- Sits beside the ALU and is driven by the same ALUOp/funct decode that feeds the ALU control.
- Implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo, and owns the HI/LO registers.
- Raises a stall request to the hazard unit while an operation is in flight.

---
 rtl/mips_mdu.sv | 171 +++++++++++++++++
 tb/tb_mips_mdu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit for the MIPS EX stage: owns HI/LO, runs
// mult/multu/div/divu over W cycles and stalls MDU instructions meanwhile.
module mips_mdu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   ALUOp,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         stall,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg2_if(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc_hi, acc_lo, opnd, a_raw;
  logic          is_div, neg_q, neg_r, div_zero;

  logic op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic op_mult, op_multu, op_div, op_divu;
  logic start_op, mdu_op;

  always_comb begin
    op_mfhi  = 1'b0;
    op_mthi  = 1'b0;
    op_mflo  = 1'b0;
    op_mtlo  = 1'b0;
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    if (en && ALUOp == 2'b10) begin
      case (funct)
        6'b010000: op_mfhi  = 1'b1;
        6'b010001: op_mthi  = 1'b1;
        6'b010010: op_mflo  = 1'b1;
        6'b010011: op_mtlo  = 1'b1;
        6'b011000: op_mult  = 1'b1;
        6'b011001: op_multu = 1'b1;
        6'b011010: op_div   = 1'b1;
        6'b011011: op_divu  = 1'b1;
        default:   ;
      endcase
    end
  end

  assign start_op     = op_mult | op_multu | op_div | op_divu;
  assign mdu_op       = start_op | op_mfhi | op_mthi | op_mflo | op_mtlo;
  assign busy         = (state != IDLE);
  assign stall        = mdu_op && busy;
  assign result_valid = (op_mfhi | op_mflo) && !stall;
  assign result       = !result_valid ? '0 : (op_mfhi ? hi : lo);

  // One iteration: shift-add for multiply, restoring subtract-shift for divide.
  logic [W:0]   mul_sum, rem_sh, rem_diff;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc_hi, acc_lo[W-1]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (!is_div) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else if (!rem_diff[W]) begin
      step_hi = rem_diff[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b1};
    end else begin
      step_hi = rem_sh[W-1:0];
      step_lo = {acc_lo[W-2:0], 1'b0};
    end
  end

  // Sign correction and divide-by-zero override applied in FIX.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg2_if({acc_hi, acc_lo}, neg_q);
    if (!is_div) begin
      fix_hi = prod_fix[2*W-1:W];
      fix_lo = prod_fix[W-1:0];
    end else if (div_zero) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_hi = neg_if(acc_hi, neg_r);
      fix_lo = neg_if(acc_lo, neg_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_op) begin
            is_div   <= op_div | op_divu;
            neg_q    <= (op_mult | op_div) & (a[W-1] ^ b[W-1]);
            neg_r    <= op_div & a[W-1];
            div_zero <= (b == '0);
            a_raw    <= a;
            acc_hi   <= '0;
            cnt      <= '0;
            if (op_div | op_divu) begin
              acc_lo <= mag(a, op_div);
              opnd   <= mag(b, op_div);
            end else begin
              acc_lo <= mag(b, op_mult);
              opnd   <= mag(a, op_mult);
            end
            state <= CALC;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (op_mthi && !stall) hi <= a;
      if (op_mtlo && !stall) lo <= a;
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: a cycle-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, stall, result_valid;
  logic [31:0] result, hi, lo;

  int npass = 0;
  int ntotal = 0;
  logic chk_on = 1'b0;

  mips_mdu #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ALUOp(ALUOp), .funct(funct),
    .a(a), .b(b), .busy(busy), .stall(stall), .result(result),
    .result_valid(result_valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    else npass++;
  endtask

  function automatic logic is_mdu(input logic e, input logic [1:0] op, input logic [5:0] f);
    return e && op == 2'b10 && (f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  // Returns {hi, lo} for a completed mult/multu/div/divu.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (f)
      6'h18: res = 64'(sx * sy);
      6'h19: res = {32'b0, x} * {32'b0, y};
      6'h1A: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {32'(r), 32'(q)};
        end
      end
      6'h1B: res = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an accepted op keeps the unit busy for 33 cycles then commits.
  int          mdl_left = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;
  logic [63:0] mdl_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_left = 0;
      mdl_hi = '0;
      mdl_lo = '0;
    end else if (mdl_left > 0) begin
      mdl_left = mdl_left - 1;
      if (mdl_left == 0) {mdl_hi, mdl_lo} = mdl_pend;
    end else if (en && ALUOp == 2'b10) begin
      if (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
        mdl_pend = ref_op(funct, a, b);
        mdl_left = 33;
      end else if (funct == 6'h11) mdl_hi = a;
      else if (funct == 6'h13) mdl_lo = a;
    end
  end

  logic        e_busy, e_stall, e_rv;
  logic [31:0] e_res;

  always @(negedge clk) begin
    if (chk_on) begin
      e_busy  = (mdl_left != 0);
      e_stall = is_mdu(en, ALUOp, funct) && e_busy;
      e_rv    = en && ALUOp == 2'b10 && (funct == 6'h10 || funct == 6'h12) && !e_stall;
      e_res   = !e_rv ? 32'h0 : (funct == 6'h10 ? mdl_hi : mdl_lo);
      chk("m_busy", {31'b0, busy}, {31'b0, e_busy});
      chk("m_stall", {31'b0, stall}, {31'b0, e_stall});
      chk("m_rvalid", {31'b0, result_valid}, {31'b0, e_rv});
      chk("m_result", result, e_res);
      chk("m_hi", hi, mdl_hi);
      chk("m_lo", lo, mdl_lo);
    end
  end

  task automatic drive(input logic e, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    en = e; ALUOp = op; funct = f; a = x; b = y;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int nbusy);
    drive(1'b1, 2'b10, f, x, y);
    nop();
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
  endtask

  int nb;

  initial begin
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(6'h19, 32'd7, 32'd6, nb);
    chk("multu_busy_cycles", nb, 32'd33);
    chk("multu_hi", hi, 32'h0);
    chk("multu_lo", lo, 32'h0000002A);

    // mult followed immediately by mfhi, which must wait out the operation.
    drive(1'b1, 2'b10, 6'h18, 32'hFFFFFFFD, 32'd5);
    drive(1'b1, 2'b10, 6'h10, 32'h0, 32'h0);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      nb++;
    end
    chk("mfhi_stall_cycles", nb, 32'd33);
    chk("mfhi_result", result, 32'hFFFFFFFF);
    chk("mfhi_valid", {31'b0, result_valid}, 32'h1);
    nop();
    @(negedge clk);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run_op(6'h1A, 32'hFFFFFFF9, 32'd2, nb);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(6'h1B, 32'hFFFFFFF9, 32'd2, nb);
    chk("divu_lo", lo, 32'h7FFFFFFC);
    chk("divu_hi", hi, 32'h1);
    run_op(6'h1B, 32'h1234, 32'h0, nb);
    chk("divz_busy_cycles", nb, 32'd33);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'h00001234);
    run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, nb);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    drive(1'b1, 2'b10, 6'h11, 32'hDEADBEEF, 32'h0);
    drive(1'b1, 2'b10, 6'h12, 32'h0, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mflo_result", result, 32'h80000000);
    chk("mflo_nostall", {31'b0, stall}, 32'h0);
    drive(1'b1, 2'b10, 6'h10, 32'h0, 32'h0);
    @(negedge clk);
    chk("mfhi2_result", result, 32'hDEADBEEF);
    chk("mfhi2_valid", {31'b0, result_valid}, 32'h1);

    // A non-MDU R-type during a busy multiply proceeds without stalling.
    drive(1'b1, 2'b10, 6'h18, 32'd100, 32'd200);
    drive(1'b1, 2'b10, 6'h20, 32'h5, 32'h6);
    @(negedge clk);
    chk("add_busy", {31'b0, busy}, 32'h1);
    chk("add_nostall", {31'b0, stall}, 32'h0);
    chk("add_nores", {31'b0, result_valid}, 32'h0);
    nop();
    repeat (40) @(negedge clk);
    chk("mult2_lo", lo, 32'd20000);

    // Reset mid-operation abandons it and clears HI/LO at once.
    drive(1'b1, 2'b10, 6'h18, 32'd5, 32'd6);
    nop();
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(6'h19, 32'd3, 32'd3, nb);
    chk("post_rst_lo", lo, 32'd9);
    chk("post_rst_hi", hi, 32'd0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
